// File: rtl/transpose_tile_ctrl.sv
// Ping-pong tile sequencer for the transpose datapath: row writes into one
// bank while the other bank drains column-by-column into the output FIFO.
module transpose_tile_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int LINE_WIDTH = 512
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   enable,
  input  logic                                   in_empty,
  output logic                                   in_re,
  output logic                                   buf_we,
  output logic                                   buf_wr_bank,
  output logic [$clog2(LINE_WIDTH/DATA_WIDTH)-1:0] buf_wr_row,
  output logic                                   buf_re,
  output logic                                   buf_rd_bank,
  output logic [$clog2(LINE_WIDTH/DATA_WIDTH)-1:0] buf_rd_col,
  input  logic                                   out_afull,
  output logic                                   out_we,
  output logic                                   tile_done,
  output logic [15:0]                            tile_cnt
);

  localparam int N     = LINE_WIDTH / DATA_WIDTH;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  bank_state_e      bank_q [2];
  logic             wr_bank_q;
  logic             rd_bank_q;
  logic [IDX_W-1:0] row_q;
  logic [IDX_W-1:0] col_q;
  logic             out_we_q;
  logic             tile_done_q;
  logic [15:0]      tile_cnt_q;

  logic wr_room;
  logic rd_avail;
  logic wr_fire;
  logic rd_fire;

  assign wr_room  = (bank_q[wr_bank_q] == EMPTY) || (bank_q[wr_bank_q] == FILLING);
  assign rd_avail = (bank_q[rd_bank_q] == FULL)  || (bank_q[rd_bank_q] == DRAINING);

  // Qualified by reset_n so the pop strobe is already low while reset is held.
  assign wr_fire = reset_n & enable & ~in_empty & wr_room;
  assign rd_fire = reset_n & rd_avail & ~out_afull;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q[0]   <= EMPTY;
      bank_q[1]   <= EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      out_we_q    <= 1'b0;
      tile_done_q <= 1'b0;
      tile_cnt_q  <= '0;
    end else begin
      out_we_q    <= rd_fire;
      tile_done_q <= rd_fire && (col_q == LAST_IDX);

      // Write and read never target the same bank: their legal states are disjoint.
      if (wr_fire) begin
        if (row_q == LAST_IDX) begin
          bank_q[wr_bank_q] <= FULL;
          row_q             <= '0;
          wr_bank_q         <= ~wr_bank_q;
        end else begin
          bank_q[wr_bank_q] <= FILLING;
          row_q             <= row_q + 1'b1;
        end
      end

      // The count moves at the same edge that raises tile_done.
      if (rd_fire) begin
        if (col_q == LAST_IDX) begin
          bank_q[rd_bank_q] <= EMPTY;
          col_q             <= '0;
          rd_bank_q         <= ~rd_bank_q;
          tile_cnt_q        <= tile_cnt_q + 16'd1;
        end else begin
          bank_q[rd_bank_q] <= DRAINING;
          col_q             <= col_q + 1'b1;
        end
      end
    end
  end

  assign in_re       = wr_fire;
  assign buf_we      = wr_fire;
  assign buf_wr_bank = wr_bank_q;
  assign buf_wr_row  = row_q;
  assign buf_re      = rd_fire;
  assign buf_rd_bank = rd_bank_q;
  assign buf_rd_col  = col_q;
  assign out_we      = out_we_q;
  assign tile_done   = tile_done_q;
  assign tile_cnt    = tile_cnt_q;

endmodule

// File: tb/tb_transpose_tile_ctrl.sv
// Randomised and directed bench for transpose_tile_ctrl, checked against a
// tile-count model (rows in / columns out) of the ping-pong buffer.
module tb_transpose_tile_ctrl;

  localparam int N     = 32;
  localparam int IDX_W = 5;

  logic             clk;
  logic             reset_n;
  logic             enable;
  logic             in_empty;
  logic             in_re;
  logic             buf_we;
  logic             buf_wr_bank;
  logic [IDX_W-1:0] buf_wr_row;
  logic             buf_re;
  logic             buf_rd_bank;
  logic [IDX_W-1:0] buf_rd_col;
  logic             out_afull;
  logic             out_we;
  logic             tile_done;
  logic [15:0]      tile_cnt;

  transpose_tile_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .in_empty    (in_empty),
    .in_re       (in_re),
    .buf_we      (buf_we),
    .buf_wr_bank (buf_wr_bank),
    .buf_wr_row  (buf_wr_row),
    .buf_re      (buf_re),
    .buf_rd_bank (buf_rd_bank),
    .buf_rd_col  (buf_rd_col),
    .out_afull   (out_afull),
    .out_we      (out_we),
    .tile_done   (tile_done),
    .tile_cnt    (tile_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: a row stream and a column stream; tile t lives in bank t%2.
  int          rows_in;
  int          cols_out;
  logic        prev_rd;
  logic        prev_last;
  logic [15:0] m_tcnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    rows_in   = 0;
    cols_out  = 0;
    prev_rd   = 1'b0;
    prev_last = 1'b0;
    m_tcnt    = '0;
  endtask

  task automatic cycle(input logic en, input logic emp, input logic af);
    logic exp_wr;
    logic exp_rd;
    @(negedge clk);
    enable    = en;
    in_empty  = emp;
    out_afull = af;
    #1;
    exp_wr = en && !emp && ((rows_in / N) - (cols_out / N) < 2);
    exp_rd = ((cols_out / N) < (rows_in / N)) && !af;
    check_eq("in_re",       32'(in_re),       32'(exp_wr));
    check_eq("buf_we",      32'(buf_we),      32'(exp_wr));
    check_eq("wr_bank",     32'(buf_wr_bank), 32'((rows_in / N) % 2));
    check_eq("wr_row",      32'(buf_wr_row),  32'(rows_in % N));
    check_eq("buf_re",      32'(buf_re),      32'(exp_rd));
    check_eq("rd_bank",     32'(buf_rd_bank), 32'((cols_out / N) % 2));
    check_eq("rd_col",      32'(buf_rd_col),  32'(cols_out % N));
    check_eq("out_we",      32'(out_we),      32'(prev_rd));
    check_eq("tile_done",   32'(tile_done),   32'(prev_last));
    check_eq("tile_cnt",    32'(tile_cnt),    32'(m_tcnt));
    if (tile_done)
      $display("tile done: tile_cnt=%0d t=%0t", tile_cnt, $time);
    prev_rd   = exp_rd;
    prev_last = exp_rd && (cols_out % N == N - 1);
    if (prev_last) m_tcnt = m_tcnt + 16'd1;
    if (exp_wr) rows_in++;
    if (exp_rd) cols_out++;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && (cols_out / N) < (rows_in / N); i++)
      cycle(1'b0, 1'b1, 1'b0);
    check_eq("drain_done", 32'((cols_out / N) < (rows_in / N)), 32'd0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    @(negedge clk);
    enable   = 1'b1;
    in_empty = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_in_re",   32'(in_re),     32'd0);
    check_eq("rst_buf_re",  32'(buf_re),    32'd0);
    check_eq("rst_out_we",  32'(out_we),    32'd0);
    check_eq("rst_tcnt",    32'(tile_cnt),  32'd0);
    check_eq("rst_wr_row",  32'(buf_wr_row), 32'd0);
    repeat (2) @(posedge clk);
    #2 enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int start_tiles;
    bit done;
    reset_n   = 1'b0;
    enable    = 1'b0;
    in_empty  = 1'b1;
    out_afull = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Single tile, then full drain.
    for (int i = 0; i < N; i++) cycle(1'b1, 1'b0, 1'b0);
    drain(200);
    check_eq("t1_tile_cnt", 32'(tile_cnt), 32'd1);

    // Streaming four tiles back-to-back.
    for (int i = 0; i < 400 && rows_in < 5 * N; i++) cycle(1'b1, 1'b0, 1'b0);
    check_eq("t2_rows", 32'(rows_in), 32'(5 * N));
    drain(200);
    check_eq("t2_tile_cnt", 32'(tile_cnt), 32'd5);

    // Output backpressure for 5 cycles while column 10 is pending.
    done = 0;
    for (int i = 0; i < 400 && rows_in < 7 * N; i++) begin
      if (!done && (cols_out % N == 10) && ((cols_out / N) < (rows_in / N))) begin
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b1);
        done = 1;
      end else begin
        cycle(1'b1, 1'b0, 1'b0);
      end
    end
    check_eq("t3_stall_hit", 32'(done), 32'd1);
    drain(200);
    check_eq("t3_tile_cnt", 32'(tile_cnt), 32'd7);

    // Input gaps every other cycle.
    for (int i = 0; i < 2 * N + 4; i++) cycle(1'b1, 1'(i % 2), 1'b0);
    drain(200);

    // enable dropped at row 8 while the other bank is full.
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if ((rows_in % N == 8) && (rows_in / N) > (cols_out / N) + 1 - 1 && rows_in > N) begin
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 1'b0);
        done = 1;
      end else begin
        cycle(1'b1, 1'b0, 1'b0);
      end
    end
    check_eq("t6_pause_hit", 32'(done), 32'd1);
    check_eq("t6_row_held", 32'(buf_wr_row), 32'd8);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0);
    drain(200);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) < 3),
            1'($urandom_range(0, 9) < 2));
    drain(300);
    start_tiles = int'(m_tcnt);
    check_eq("rand_tile_cnt", 32'(tile_cnt), 32'(start_tiles));

    // Reset in the middle of filling at row 17.
    for (int i = 0; i < 100 && (rows_in % N != 17 || rows_in < N); i++)
      cycle(1'b1, 1'b0, 1'b0);
    check_eq("t5_at_row17", 32'(rows_in % N), 32'd17);
    async_reset();
    cycle(1'b1, 1'b0, 1'b0);
    check_eq("t5_cnt_zero", 32'(tile_cnt), 32'd0);
    for (int i = 0; i < N + 4; i++) cycle(1'b1, 1'b0, 1'b0);
    drain(200);
    check_eq("t5_tile_cnt", 32'(tile_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
